// File: rtl/div_seq.sv
// Multi-cycle radix-2 restoring divider (signed/unsigned, cancellable) for DIV/DIVU.
// Optional DIV_EARLY_TERM_EN: skip iterations when |divisor| > |dividend|.
module div_seq #(
   parameter int unsigned WIDTH = 32
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start_i,
   input  logic               signed_i,
   input  logic [WIDTH-1:0]   opdata1_i,
   input  logic [WIDTH-1:0]   opdata2_i,
   input  logic               annul_i,
   output logic [2*WIDTH-1:0] result_o,
   output logic               ready_o,
   output logic               busy_o
);

   localparam int unsigned CW = $clog2(WIDTH) + 1;

   typedef enum logic [1:0] {S_IDLE, S_ON, S_END, S_DZERO} state_t;

   state_t             state, state_nx;
   logic [CW-1:0]      cnt, cnt_nx;
   logic [WIDTH-1:0]   dvd, dvd_nx;
   logic [WIDTH-1:0]   dvs, dvs_nx;
   logic [WIDTH-1:0]   rem, rem_nx;
   logic               neg_q, neg_q_nx;
   logic               neg_r, neg_r_nx;
   logic [2*WIDTH-1:0] result_nx;
   logic               ready_nx;
   logic               busy_nx;

   logic [WIDTH-1:0]   mag1, mag2;
   logic [WIDTH:0]     shifted, diff;
   logic [WIDTH-1:0]   q_fix, r_fix;

   // Unsigned magnitudes; the most-negative value maps to 2^(WIDTH-1) exactly
   assign mag1 = (signed_i && opdata1_i[WIDTH-1]) ? (~opdata1_i + WIDTH'(1)) : opdata1_i;
   assign mag2 = (signed_i && opdata2_i[WIDTH-1]) ? (~opdata2_i + WIDTH'(1)) : opdata2_i;

   // One restoring step: shift {rem, dvd} and trial-subtract; diff MSB set means "restore"
   assign shifted = {rem, dvd[WIDTH-1]};
   assign diff    = shifted - {1'b0, dvs};

   assign q_fix = neg_q ? (~dvd + WIDTH'(1)) : dvd;
   assign r_fix = neg_r ? (~rem + WIDTH'(1)) : rem;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= S_IDLE;
      else      state <= state_nx;
   end

   always_comb begin
      state_nx  = state;
      cnt_nx    = cnt;
      dvd_nx    = dvd;
      dvs_nx    = dvs;
      rem_nx    = rem;
      neg_q_nx  = neg_q;
      neg_r_nx  = neg_r;
      result_nx = result_o;
      ready_nx  = 1'b0;

      case (state)
         S_IDLE: begin
            if (start_i && !annul_i) begin
               neg_q_nx = signed_i & (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
               neg_r_nx = signed_i & opdata1_i[WIDTH-1];
               cnt_nx   = '0;
               if (opdata2_i == '0) begin
                  state_nx = S_DZERO;
                  dvd_nx   = opdata1_i;
               end else begin
                  dvs_nx = mag2;
`ifdef DIV_EARLY_TERM_EN
                  if (mag2 > mag1) begin
                     state_nx = S_END;
                     dvd_nx   = '0;
                     rem_nx   = mag1;
                  end else
`endif
                  begin
                     state_nx = S_ON;
                     dvd_nx   = mag1;
                     rem_nx   = '0;
                  end
               end
            end
         end
         S_ON: begin
            rem_nx = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
            dvd_nx = {dvd[WIDTH-2:0], ~diff[WIDTH]};
            cnt_nx = cnt + CW'(1);
            if (cnt == CW'(WIDTH - 1)) state_nx = S_END;
         end
         S_END: begin
            state_nx  = S_IDLE;
            result_nx = {r_fix, q_fix};
            ready_nx  = 1'b1;
         end
         S_DZERO: begin
            state_nx  = S_IDLE;
            result_nx = {dvd, {WIDTH{1'b1}}};
            ready_nx  = 1'b1;
         end
         default: state_nx = S_IDLE;
      endcase

      // Flush wins over every in-flight state, including the completion cycle
      if (annul_i && state != S_IDLE) begin
         state_nx  = S_IDLE;
         result_nx = result_o;
         ready_nx  = 1'b0;
      end

      busy_nx = (state_nx != S_IDLE);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt      <= '0;
         dvd      <= '0;
         dvs      <= '0;
         rem      <= '0;
         neg_q    <= 1'b0;
         neg_r    <= 1'b0;
         result_o <= '0;
         ready_o  <= 1'b0;
         busy_o   <= 1'b0;
      end else begin
         cnt      <= cnt_nx;
         dvd      <= dvd_nx;
         dvs      <= dvs_nx;
         rem      <= rem_nx;
         neg_q    <= neg_q_nx;
         neg_r    <= neg_r_nx;
         result_o <= result_nx;
         ready_o  <= ready_nx;
         busy_o   <= busy_nx;
      end
   end

endmodule

// File: tb/tb_div_seq.sv
// Bench for div_seq: directed vector table, multi-cycle corner sequences, random ops vs arithmetic model.
module tb_div_seq;

   localparam int unsigned W = 32;

   logic           clk = 1'b0;
   logic           rst;
   logic           start_i;
   logic           signed_i;
   logic [W-1:0]   opdata1_i;
   logic [W-1:0]   opdata2_i;
   logic           annul_i;
   logic [2*W-1:0] result_o;
   logic           ready_o;
   logic           busy_o;

   int tests = 0;
   int fails = 0;

   div_seq #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst), .start_i(start_i), .signed_i(signed_i),
      .opdata1_i(opdata1_i), .opdata2_i(opdata2_i), .annul_i(annul_i),
      .result_o(result_o), .ready_o(ready_o), .busy_o(busy_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic         sgn;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] q;
      logic [W-1:0] r;
   } vec_t;

   vec_t vecs[11];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Reference: plain 64-bit arithmetic; SV division truncates and % follows the dividend's sign
   function automatic void model(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b,
                                 output logic [2*W-1:0] res, output int lat);
      longint sa, sb, q, r, ma, mb;
      if (sgn) begin
         sa = longint'($signed(a));
         sb = longint'($signed(b));
      end else begin
         sa = longint'(a);
         sb = longint'(b);
      end
      if (b == '0) begin
         res = {a, {W{1'b1}}};
         lat = 1;
         return;
      end
      q   = sa / sb;
      r   = sa % sb;
      res = {r[W-1:0], q[W-1:0]};
      ma  = (sa < 0) ? -sa : sa;
      mb  = (sb < 0) ? -sb : sb;
      lat = W + 1;
`ifdef DIV_EARLY_TERM_EN
      if (mb > ma) lat = 1;
`else
      if (mb > ma) lat = W + 1;
`endif
   endfunction

   task automatic run_div(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [2*W-1:0] exp_res, input int exp_lat, input string tag);
      int cyc;
      cyc = 0;
      @(negedge clk);
      start_i = 1'b1; signed_i = sgn; opdata1_i = a; opdata2_i = b;
      @(posedge clk); #1;
      start_i = 1'b0;
      check({tag, "_busy_e0"}, 64'(busy_o), 64'd1);
      for (int c = 1; c <= int'(W) + 10; c++) begin
         @(posedge clk); #1;
         if (ready_o) begin
            cyc = c;
            break;
         end
      end
      check({tag, "_lat"}, 64'(cyc), 64'(exp_lat));
      check({tag, "_res"}, result_o, exp_res);
      check({tag, "_busy_done"}, 64'(busy_o), 64'd0);
      @(posedge clk); #1;
      check({tag, "_ready_pulse"}, 64'(ready_o), 64'd0);
   endtask

   initial begin
      logic [2*W-1:0] mres;
      logic [2*W-1:0] prev;
      logic [W-1:0]   ra, rb;
      logic           rs;
      int             mlat;
      int             cyc;
      int             nready;

      vecs[0]  = '{1'b0, 32'd100,        32'd7,          32'd14,         32'd2};
      vecs[1]  = '{1'b1, 32'hFFFFFFF9,   32'd2,          32'hFFFFFFFD,   32'hFFFFFFFF};
      vecs[2]  = '{1'b1, 32'd7,          32'hFFFFFFFE,   32'hFFFFFFFD,   32'd1};
      vecs[3]  = '{1'b1, 32'h80000000,   32'hFFFFFFFF,   32'h80000000,   32'd0};
      vecs[4]  = '{1'b0, 32'h80000000,   32'hFFFFFFFF,   32'd0,          32'h80000000};
      vecs[5]  = '{1'b0, 32'd5,          32'd0,          32'hFFFFFFFF,   32'd5};
      vecs[6]  = '{1'b1, 32'hFFFFFFFB,   32'd0,          32'hFFFFFFFF,   32'hFFFFFFFB};
      vecs[7]  = '{1'b0, 32'hFFFFFFFF,   32'd1,          32'hFFFFFFFF,   32'd0};
      vecs[8]  = '{1'b1, 32'hFFFFFFFF,   32'hFFFFFFFF,   32'd1,          32'd0};
      vecs[9]  = '{1'b1, 32'h80000000,   32'd2,          32'hC0000000,   32'd0};
      vecs[10] = '{1'b0, 32'd0,          32'd3,          32'd0,          32'd0};

      rst = 1'b0; start_i = 1'b0; signed_i = 1'b0; annul_i = 1'b0;
      opdata1_i = '0; opdata2_i = '0;
      #12;
      check("reset_result", result_o, 64'd0);
      check("reset_ready", 64'(ready_o), 64'd0);
      check("reset_busy", 64'(busy_o), 64'd0);
      @(negedge clk); rst = 1'b1;

      for (int i = 0; i < 11; i++) begin
         model(vecs[i].sgn, vecs[i].a, vecs[i].b, mres, mlat);
         run_div(vecs[i].sgn, vecs[i].a, vecs[i].b, {vecs[i].r, vecs[i].q}, mlat,
                 $sformatf("vec%0d", i));
      end

      // Flush at iteration 10 of 100/7: no completion, result keeps the previous value
      prev = result_o;
      @(negedge clk);
      start_i = 1'b1; signed_i = 1'b0; opdata1_i = 32'd100; opdata2_i = 32'd7;
      @(posedge clk); #1; start_i = 1'b0;
      repeat (9) @(posedge clk);
      @(negedge clk); annul_i = 1'b1;
      @(posedge clk); #1;
      check("annul_busy", 64'(busy_o), 64'd0);
      check("annul_ready", 64'(ready_o), 64'd0);
      check("annul_result", result_o, prev);
      annul_i = 1'b0;
      nready = 0;
      for (int c = 0; c < 40; c++) begin
         @(posedge clk); #1;
         if (ready_o) nready++;
      end
      check("annul_no_ready", 64'(nready), 64'd0);
      check("annul_result_held", result_o, prev);
      model(1'b0, 32'd9, 32'd3, mres, mlat);
      run_div(1'b0, 32'd9, 32'd3, {32'd0, 32'd3}, mlat, "after_annul");

      // Start while busy must not disturb the in-flight 100/7
      @(negedge clk);
      start_i = 1'b1; signed_i = 1'b0; opdata1_i = 32'd100; opdata2_i = 32'd7;
      @(posedge clk); #1; start_i = 1'b0;
      repeat (5) @(posedge clk);
      @(negedge clk);
      start_i = 1'b1; signed_i = 1'b1; opdata1_i = 32'd50; opdata2_i = 32'hFFFFFFFB;
      @(posedge clk); #1; start_i = 1'b0;
      cyc = 0;
      for (int c = 7; c <= int'(W) + 10; c++) begin
         @(posedge clk); #1;
         if (ready_o) begin
            cyc = c;
            break;
         end
      end
      check("busy_start_lat", 64'(cyc), 64'(W + 1));
      check("busy_start_res", result_o, {32'd2, 32'd14});

      // Start together with annul in IDLE is dropped
      @(negedge clk);
      start_i = 1'b1; annul_i = 1'b1; opdata1_i = 32'd8; opdata2_i = 32'd2;
      @(posedge clk); #1;
      start_i = 1'b0; annul_i = 1'b0;
      check("annul_start_busy", 64'(busy_o), 64'd0);
      nready = 0;
      for (int c = 0; c < 5; c++) begin
         @(posedge clk); #1;
         if (ready_o || busy_o) nready++;
      end
      check("annul_start_idle", 64'(nready), 64'd0);

      // Asynchronous reset between edges mid-division
      @(negedge clk);
      start_i = 1'b1; signed_i = 1'b0; opdata1_i = 32'd1000; opdata2_i = 32'd3;
      @(posedge clk); #1; start_i = 1'b0;
      repeat (4) @(posedge clk);
      #3 rst = 1'b0;
      #1;
      check("mid_rst_result", result_o, 64'd0);
      check("mid_rst_busy", 64'(busy_o), 64'd0);
      check("mid_rst_ready", 64'(ready_o), 64'd0);
      @(negedge clk); rst = 1'b1;
      model(1'b0, 32'd1000, 32'd3, mres, mlat);
      run_div(1'b0, 32'd1000, 32'd3, mres, mlat, "after_rst");

      for (int i = 0; i < 40; i++) begin
         rs = 1'($urandom_range(0, 1));
         ra = $urandom;
         case ($urandom_range(0, 3))
            0:       rb = $urandom;
            1:       rb = W'($urandom_range(0, 20));
            2:       rb = ra >> $urandom_range(1, 31);
            default: rb = ~W'($urandom_range(0, 9));
         endcase
         model(rs, ra, rb, mres, mlat);
         run_div(rs, ra, rb, mres, mlat, $sformatf("rnd%0d", i));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
